// File: rtl/multiplier_if.sv
// Operand/product bundle for the unsigned array multiplier.
interface multiplier_if #(
    parameter int unsigned p_width = 6
);
    logic [p_width-1:0]   i_w_a;
    logic [p_width-1:0]   i_w_b;
    logic [2*p_width-1:0] o_w_p;

    modport master (output i_w_a, output i_w_b, input o_w_p);
    modport slave  (input i_w_a, input i_w_b, output o_w_p);
endinterface

// File: rtl/multiplier.sv
// Unsigned p_width x p_width array multiplier built from explicit partial products.
// The full 2*p_width product is registered, so latency is one cycle.
module multiplier #(
    parameter int unsigned p_width = 6
) (
    input  logic          i_w_clk,
    input  logic          i_w_rst_n,
    multiplier_if.slave   bus
);
    localparam int unsigned p_pw = 2 * p_width;

    logic [p_pw-1:0] pp  [p_width];
    logic [p_pw-1:0] sum [p_width+1];

    assign sum[0] = '0;

    // Row k: operand A gated by bit k of B, aligned to weight 2^k, then accumulated.
    for (genvar k = 0; k < p_width; k++) begin : g_row
        assign pp[k]    = {{p_width{1'b0}}, bus.i_w_a & {p_width{bus.i_w_b[k]}}} << k;
        assign sum[k+1] = sum[k] + pp[k];
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n)
            bus.o_w_p <= '0;
        else
            bus.o_w_p <= sum[p_width];
    end
endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the 6-bit array multiplier: reset, identities, sweep, range, glitches.
module tb_multiplier;
    localparam int unsigned W = 6;

    logic i_w_clk   = 1'b0;
    logic i_w_rst_n = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    multiplier_if #(.p_width(W)) bus ();

    multiplier #(.p_width(W)) dut (
        .i_w_clk   (i_w_clk),
        .i_w_rst_n (i_w_rst_n),
        .bus       (bus.slave)
    );

    always #5 i_w_clk = ~i_w_clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input int unsigned a, input int unsigned b);
        bus.i_w_a = a[W-1:0];
        bus.i_w_b = b[W-1:0];
    endtask

    task automatic step;
        @(posedge i_w_clk);
        #1;
    endtask

    initial begin
        apply(5, 7);
        #2 i_w_rst_n = 1'b0;
        #1 chk("reset_immediate", bus.o_w_p, 12'd0);
        step();
        chk("reset_held_1", bus.o_w_p, 12'd0);
        step();
        chk("reset_held_2", bus.o_w_p, 12'd0);
        #2 i_w_rst_n = 1'b1;
        #1 chk("reset_release_no_edge", bus.o_w_p, 12'd0);
        step();
        chk("reset_release_35", bus.o_w_p, 12'd35);

        apply(0, 13);  step(); chk("zero_a", bus.o_w_p, 12'd0);
        apply(1, 13);  step(); chk("ident_a", bus.o_w_p, 12'd13);
        apply(13, 1);  step(); chk("ident_b", bus.o_w_p, 12'd13);
        apply(13, 0);  step(); chk("zero_b", bus.o_w_p, 12'd0);

        for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                int unsigned prod;
                prod = a * b;
                apply(a, b);
                step();
                chk($sformatf("sweep_%0dx%0d", a, b), bus.o_w_p, prod[2*W-1:0]);
            end
        end

        apply(63, 63); step(); chk("full_63x63", bus.o_w_p, 12'hF81);
        apply(63, 1);  step(); chk("full_63x1", bus.o_w_p, 12'd63);
        apply(32, 32); step(); chk("full_32x32", bus.o_w_p, 12'd1024);
        apply(1, 63);  step(); chk("full_1x63", bus.o_w_p, 12'd63);
        apply(62, 63); step(); chk("full_62x63", bus.o_w_p, 12'd3906);

        apply(10, 10); step(); chk("mid_pre", bus.o_w_p, 12'd100);
        #1 i_w_rst_n = 1'b0;
        #1 chk("mid_reset_immediate", bus.o_w_p, 12'd0);
        #1 i_w_rst_n = 1'b1;
        #1 chk("mid_released_hold", bus.o_w_p, 12'd0);
        step();
        chk("mid_after_edge", bus.o_w_p, 12'd100);

        apply(3, 2);   #1 chk("glitch_a3", bus.o_w_p, 12'd100);
        apply(60, 2);  #1 chk("glitch_a60", bus.o_w_p, 12'd100);
        apply(3, 2);   #1 chk("glitch_a3_again", bus.o_w_p, 12'd100);
        apply(7, 2);   #1 chk("glitch_settled_pre_edge", bus.o_w_p, 12'd100);
        step();
        chk("glitch_edge_14", bus.o_w_p, 12'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
